// File: rtl/typed_shadow_regs_pkg.sv
// Shared types for the typed shadow register block: FSM state and 1-bit flags.
package typed_regs_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    COMMIT = 1'b1
  } state_t;

  typedef logic flag_t;

endpackage

// File: rtl/typed_shadow_regs_if.sv
// Write/commit/read bus of the typed shadow register block.
interface typed_shadow_regs_if
  import typed_regs_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
);
  localparam int CHAN_W = $clog2(CHANNELS);
  typedef logic [WIDTH-1:0] elem_t;

  logic                wr_valid;
  logic                wr_ready;
  logic [CHAN_W-1:0]   wr_chan;
  elem_t               wr_data;
  logic                commit;
  logic                commit_done;
  logic [CHAN_W-1:0]   rd_chan;
  elem_t               rd_data;
  logic [CHANNELS-1:0] dirty;
  flag_t               err;

  modport master (
    output wr_valid, wr_chan, wr_data, commit, rd_chan,
    input  wr_ready, commit_done, rd_data, dirty, err
  );

  modport slave (
    input  wr_valid, wr_chan, wr_data, commit, rd_chan,
    output wr_ready, commit_done, rd_data, dirty, err
  );

endinterface

// File: rtl/typed_shadow_regs_cell.sv
// One shadow/active register pair with its dirty flag.
module shadow_cell #(
  parameter int              WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (clk, rst, wr_en, wr_data, commit_en, active, dirty);
  import typed_regs_pkg::*;
  typedef logic [WIDTH-1:0] elem_t;

  input  logic  clk;
  input  logic  rst;
  input  logic  wr_en;
  input  elem_t wr_data;
  input  logic  commit_en;
  output elem_t active;
  output flag_t dirty;

  elem_t shadow;

  // A commit only copies when a write is pending; writes never coincide with commits.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow <= RESET_VAL;
      active <= RESET_VAL;
      dirty  <= 1'b0;
    end else begin
      if (commit_en && dirty) begin
        active <= shadow;
        dirty  <= 1'b0;
      end
      if (wr_en) begin
        shadow <= wr_data;
        dirty  <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/typed_shadow_regs.sv
// Shadow/active register bank: writes land in shadows, a commit scans every channel in fixed time.
module typed_shadow_regs
  import typed_regs_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               CHANNELS  = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input logic                clk,
  input logic                rst,
  typed_shadow_regs_if.slave bus
);
  localparam int CHAN_W = $clog2(CHANNELS);
  typedef logic [WIDTH-1:0] elem_t;

  state_t          state;
  state_t          state_next;
  logic [CHAN_W:0] scan_idx;
  flag_t           err_q;
  elem_t           active [CHANNELS];
  flag_t           dirty_q [CHANNELS];
  logic            wr_fire;
  logic            wr_in_range;
  logic            rd_in_range;
  logic            scan_last;

  assign wr_in_range = {1'b0, bus.wr_chan} < (CHAN_W+1)'(CHANNELS);
  assign rd_in_range = {1'b0, bus.rd_chan} < (CHAN_W+1)'(CHANNELS);
  assign scan_last   = scan_idx == (CHAN_W+1)'(CHANNELS - 1);

  assign bus.wr_ready = (state == IDLE);
  assign wr_fire      = bus.wr_valid && bus.wr_ready;
  assign bus.rd_data  = rd_in_range ? active[bus.rd_chan] : RESET_VAL;
  assign bus.err      = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      scan_idx <= '0;
      err_q    <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE && bus.commit)
        scan_idx <= '0;
      else if (state == COMMIT)
        scan_idx <= scan_idx + 1'b1;
      if ((wr_fire && !wr_in_range) || !rd_in_range)
        err_q <= 1'b1;
    end
  end

  // commit_done is masked by reset so an aborted scan never reports completion.
  always_comb begin
    state_next      = state;
    bus.commit_done = 1'b0;
    case (state)
      IDLE: begin
        if (bus.commit)
          state_next = COMMIT;
      end
      COMMIT: begin
        if (scan_last) begin
          state_next      = IDLE;
          bus.commit_done = !rst;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_cell
    shadow_cell #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_cell (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (wr_fire && wr_in_range && (bus.wr_chan == CHAN_W'(i))),
      .wr_data   (bus.wr_data),
      .commit_en ((state == COMMIT) && (scan_idx == (CHAN_W+1)'(i))),
      .active    (active[i]),
      .dirty     (dirty_q[i])
    );
    assign bus.dirty[i] = dirty_q[i];
  end

endmodule

// File: doc/typed_shadow_regs.md
TYPED_SHADOW_REGS -- requirements
Module: typed_shadow_regs

Interface
REQ-001 Parameter WIDTH, default 8: bit width of every register element.
REQ-002 Parameter CHANNELS, default 4, legal range 2..16: number of shadow/active register pairs.
REQ-003 Parameter RESET_VAL, default 0: value loaded into every shadow and active register on reset.
REQ-004 Port clk  input  1: single clock; all state updates on the rising edge.
REQ-005 Port rst  input  1: reset, synchronous and active-high.
REQ-006 Port wr_valid  input  1: write request.
REQ-007 Port wr_ready  output  1: write can be accepted; a write is accepted on a cycle with wr_valid and wr_ready both high.
REQ-008 Port wr_chan  input  CHAN_W (= $clog2(CHANNELS)): target channel of the write.
REQ-009 Port wr_data  input  WIDTH: write data.
REQ-010 Port commit  input  1: request to copy the dirty shadow registers into the active registers.
REQ-011 Port commit_done  output  1: single-cycle pulse at the end of a commit.
REQ-012 Port rd_chan  input  CHAN_W: read select.
REQ-013 Port rd_data  output  WIDTH: active value of channel rd_chan; combinational.
REQ-014 Port dirty  output  CHANNELS: per-channel flag, high when shadow differs from active by a pending write.
REQ-015 Port err  output  1: sticky flag for an out-of-range channel access.

Function
REQ-016 States are IDLE and COMMIT; the block enters IDLE on reset.
REQ-017 wr_ready is 1 in IDLE and 0 in COMMIT.
REQ-018 An accepted write stores wr_data in shadow[wr_chan] and sets dirty[wr_chan] on the next edge.
REQ-019 A second write to the same channel before a commit overwrites the shadow value; dirty stays 1.
REQ-020 In IDLE, commit=1 moves the block to COMMIT and clears the scan index to 0.
REQ-021 When a write and a commit occur in the same IDLE cycle, the write lands first and is included in that commit.
REQ-022 In COMMIT, each cycle handles the channel at the scan index:
- if that channel is dirty, active takes the shadow value and dirty clears;
- the scan index then increments.
REQ-023 After index CHANNELS-1 is handled, the block returns to IDLE and drives commit_done high for exactly that transition cycle.
REQ-024 Commit latency is fixed:
- commit_done is high on cycle N+CHANNELS when commit is sampled in cycle N;
- this holds regardless of how many channels are dirty, including none.
REQ-025 A commit asserted while in COMMIT is ignored and not queued.
REQ-026 wr_valid asserted during COMMIT has no effect; the requester holds it until wr_ready returns.
REQ-027 An accepted write, or any read, with a channel index >= CHANNELS (only possible when CHANNELS is not a power of two) is handled as follows:
- a write is discarded and does not change any shadow or dirty bit;
- a read returns RESET_VAL;
- err is set to 1 and stays 1 until reset.
REQ-028 The scan index counter is CHAN_W+1 bits wide so the end condition does not wrap early.
REQ-029 rd_data always reflects the active registers only; shadow contents are never visible on rd_data.

Reset
REQ-030 On the reset edge:
- all shadow and active registers load RESET_VAL;
- dirty clears to 0, err to 0, commit_done to 0;
- the state returns to IDLE.
REQ-031 Reset asserted mid-COMMIT aborts the commit with no commit_done pulse; reset overrides all simultaneous writes and commits.
REQ-032 No register has a declaration initialiser; reset is the only source of initial state.

Structure
REQ-033 A shared package typed_regs_pkg holds:
- the state enum typedef state_t;
- the 1-bit flag typedef flag_t, used for dirty elements and err.
REQ-034 The element type elem_t is a module-local typedef of logic [WIDTH-1:0]; all shadow, active and data signals use elem_t, and flags use the package flag_t.
REQ-035 Every typed variable has exactly one kind of driver:
- rd_data and wr_ready are driven only by continuous assignment;
- all state is driven only by clocked procedural blocks;
- no variable mixes continuous and procedural drivers.
REQ-036 One sub-module, shadow_cell, holds a single shadow/active pair plus its dirty bit and is instantiated CHANNELS times in a generate loop.

Verification
REQ-037 Scenario: reset, write ch1=0x5A, no commit -> rd_chan=1 gives 0x00; dirty=4'b0010.
REQ-038 Scenario: write ch1=0x5A, then commit -> commit_done exactly 4 cycles after commit; rd ch1=0x5A; dirty=0; wr_ready low for those 4 cycles.
REQ-039 Scenario: write ch2=0x11 and commit in the same cycle -> after commit_done, rd ch2=0x11.
REQ-040 Scenario: commit with no dirty channels, and a second commit during COMMIT -> a single commit_done after 4 cycles; all actives unchanged.
REQ-041 Scenario: writes to ch0 and ch3, then rst pulsed 2 cycles into the commit -> no commit_done; all actives and shadows = RESET_VAL; dirty=0.
REQ-042 Scenario: CHANNELS=3, write to ch3 -> err=1 sticky; dirty=0; read of ch3 gives RESET_VAL.
